// File: rtl/ex_mem_stage_reg.sv
// EX/MEM pipeline register with valid/ready handshake and 2-entry skid buffer.
// Holds branch target, ALU result, store data and control for the MEM stage.
module ex_mem_stage_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2,
   parameter int M_W    = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              flush,
   input  logic [DATA_W-1:0] adder_in,
   input  logic [DATA_W-1:0] alu_in,
   input  logic              zf_in,
   input  logic [DATA_W-1:0] rd2_in,
   input  logic [WB_W-1:0]   wb_in,
   input  logic [M_W-1:0]    m_in,
   input  logic [REG_W-1:0]  dst_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] adder_out,
   output logic [DATA_W-1:0] alu_out,
   output logic [DATA_W-1:0] rd2_out,
   output logic              zf_out,
   output logic [WB_W-1:0]   wb_out,
   output logic [M_W-1:0]    m_out,
   output logic [REG_W-1:0]  dst_out,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
);

   typedef struct packed {
      logic [DATA_W-1:0] adder;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rd2;
      logic              zf;
      logic [WB_W-1:0]   wb;
      logic [M_W-1:0]    m;
      logic [REG_W-1:0]  dst;
   } ent_t;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } state_t;

   state_t           state_q;
   ent_t             main_q;
   ent_t             skid_q;
   ent_t             in_ent;
   logic             in_ready_q;
   logic             out_valid_q;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] bubble_q, bubble_d;
   logic             accept;
   logic             drain;

   assign accept = in_valid & in_ready_q;
   assign drain  = out_valid_q & out_ready;

   // Bundle the EX-side fields into one entry.
   always_comb begin
      in_ent       = '0;
      in_ent.adder = adder_in;
      in_ent.alu   = alu_in;
      in_ent.rd2   = rd2_in;
      in_ent.zf    = zf_in;
      in_ent.wb    = wb_in;
      in_ent.m     = m_in;
      in_ent.dst   = dst_in;
   end

   // Entry FSM: main/skid storage, registered in_ready and out_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else if (flush) begin
         state_q     <= EMPTY;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_q      <= in_ent;
                  state_q     <= FULL;
                  out_valid_q <= 1'b1;
               end
            end
            FULL: begin
               if (accept && drain) begin
                  main_q <= in_ent;
               end else if (accept) begin
                  skid_q     <= in_ent;
                  state_q    <= SKID;
                  in_ready_q <= 1'b0;
               end else if (drain) begin
                  state_q     <= EMPTY;
                  out_valid_q <= 1'b0;
               end
            end
            SKID: begin
               if (drain) begin
                  main_q     <= skid_q;
                  state_q    <= FULL;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q     <= EMPTY;
               in_ready_q  <= 1'b1;
               out_valid_q <= 1'b0;
            end
         endcase
      end
   end

   // Saturating next values of the stall and bubble counters.
   always_comb begin
      stall_d  = stall_q;
      bubble_d = bubble_q;
      if (out_valid_q && !out_ready && stall_q != '1)
         stall_d = stall_q + CNT_W'(1);
      if (!out_valid_q && bubble_q != '1)
         bubble_d = bubble_q + CNT_W'(1);
   end

   // Performance counters, cleared only by reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_q  <= '0;
         bubble_q <= '0;
      end else begin
         stall_q  <= stall_d;
         bubble_q <= bubble_d;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = out_valid_q;
   assign adder_out  = main_q.adder;
   assign alu_out    = main_q.alu;
   assign rd2_out    = main_q.rd2;
   assign zf_out     = main_q.zf;
   assign dst_out    = main_q.dst;
   assign wb_out     = out_valid_q ? main_q.wb : '0;
   assign m_out      = out_valid_q ? main_q.m : '0;
   assign stall_cnt  = stall_q;
   assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed bench for ex_mem_stage_reg (CNT_W=4 build).
// Table vectors for handshake/ordering, sequences for flush, saturation, reset.
module tb_ex_mem_stage_reg;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int WB_W   = 2;
   localparam int M_W    = 3;
   localparam int CNT_W  = 4;
   localparam logic [31:0] RD2_K = 32'h5555_0000;

   logic              clk;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic              flush;
   logic [DATA_W-1:0] adder_in;
   logic [DATA_W-1:0] alu_in;
   logic              zf_in;
   logic [DATA_W-1:0] rd2_in;
   logic [WB_W-1:0]   wb_in;
   logic [M_W-1:0]    m_in;
   logic [REG_W-1:0]  dst_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] adder_out;
   logic [DATA_W-1:0] alu_out;
   logic [DATA_W-1:0] rd2_out;
   logic              zf_out;
   logic [WB_W-1:0]   wb_out;
   logic [M_W-1:0]    m_out;
   logic [REG_W-1:0]  dst_out;
   logic [CNT_W-1:0]  stall_cnt;
   logic [CNT_W-1:0]  bubble_cnt;

   ex_mem_stage_reg #(
      .DATA_W(DATA_W),
      .REG_W (REG_W),
      .WB_W  (WB_W),
      .M_W   (M_W),
      .CNT_W (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .flush     (flush),
      .adder_in  (adder_in),
      .alu_in    (alu_in),
      .zf_in     (zf_in),
      .rd2_in    (rd2_in),
      .wb_in     (wb_in),
      .m_in      (m_in),
      .dst_in    (dst_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .adder_out (adder_out),
      .alu_out   (alu_out),
      .rd2_out   (rd2_out),
      .zf_out    (zf_out),
      .wb_out    (wb_out),
      .m_out     (m_out),
      .dst_out   (dst_out),
      .stall_cnt (stall_cnt),
      .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic        ordy;
      logic [31:0] alu;
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [4:0]  dst;
      logic        e_ov;
      logic        e_ir;
      logic [31:0] e_alu;
      logic [1:0]  e_wb;
      logic [2:0]  e_m;
      logic [4:0]  e_dst;
      int          e_s;
      int          e_b;
   } vec_t;

   int checks = 0;
   int errors = 0;
   vec_t vt[17];
   int es;
   int eb;

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic iv, input logic ordy,
                               input logic [31:0] alu, input logic [1:0] wb,
                               input logic [2:0] m, input logic [4:0] dst,
                               input logic e_ov, input logic e_ir,
                               input logic [31:0] e_alu, input logic [1:0] e_wb,
                               input logic [2:0] e_m, input logic [4:0] e_dst,
                               input int e_s, input int e_b);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.alu = alu; v.wb = wb; v.m = m; v.dst = dst;
      v.e_ov = e_ov; v.e_ir = e_ir; v.e_alu = e_alu; v.e_wb = e_wb;
      v.e_m = e_m; v.e_dst = e_dst; v.e_s = e_s; v.e_b = e_b;
      return v;
   endfunction

   task automatic put(input logic iv, input logic ordy, input logic fl,
                      input logic [31:0] alu, input logic [1:0] wb,
                      input logic [2:0] m, input logic [4:0] dst);
      in_valid  = iv;
      out_ready = ordy;
      flush     = fl;
      alu_in    = alu;
      adder_in  = ~alu;
      rd2_in    = alu ^ RD2_K;
      zf_in     = (alu == 32'd0);
      wb_in     = wb;
      m_in      = m;
      dst_in    = dst;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_cnt(input string tag, input int s, input int b);
      chk({tag, ".stall"}, 32'(stall_cnt), 32'(s));
      chk({tag, ".bubble"}, 32'(bubble_cnt), 32'(b));
   endtask

   initial begin
      rst = 1'b1;
      put(1'b0, 1'b0, 1'b0, 32'd0, 2'd0, 3'd0, 5'd0);

      vt[0]  = mk(1, 1, 32'hA5, 2'b10, 3'b011, 5'd5, 1, 1, 32'hA5, 2'b10, 3'b011, 5'd5, 0, 1);
      vt[1]  = mk(0, 1, 32'h0, 2'b00, 3'b000, 5'd0, 0, 1, 32'h0, 2'b00, 3'b000, 5'd0, 0, 1);
      vt[2]  = mk(1, 1, 32'h1, 2'b01, 3'b001, 5'd1, 1, 1, 32'h1, 2'b01, 3'b001, 5'd1, 0, 2);
      vt[3]  = mk(1, 0, 32'h2, 2'b11, 3'b010, 5'd2, 1, 0, 32'h1, 2'b01, 3'b001, 5'd1, 1, 2);
      vt[4]  = mk(1, 0, 32'h3, 2'b10, 3'b100, 5'd3, 1, 0, 32'h1, 2'b01, 3'b001, 5'd1, 2, 2);
      vt[5]  = mk(1, 1, 32'h3, 2'b10, 3'b100, 5'd3, 1, 1, 32'h2, 2'b11, 3'b010, 5'd2, 2, 2);
      vt[6]  = mk(1, 1, 32'h3, 2'b10, 3'b100, 5'd3, 1, 1, 32'h3, 2'b10, 3'b100, 5'd3, 2, 2);
      vt[7]  = mk(0, 1, 32'h0, 2'b00, 3'b000, 5'd0, 0, 1, 32'h0, 2'b00, 3'b000, 5'd0, 2, 2);
      for (int i = 0; i < 8; i++)
         vt[8+i] = mk(1, 1, 32'(16 + i), 2'b01, 3'b110, 5'(i),
                      1, 1, 32'(16 + i), 2'b01, 3'b110, 5'(i), 2, 3);
      vt[16] = mk(0, 1, 32'h0, 2'b00, 3'b000, 5'd0, 0, 1, 32'h0, 2'b00, 3'b000, 5'd0, 2, 3);

      #3;
      chk("rst.out_valid", 32'(out_valid), 32'd0);
      chk("rst.in_ready", 32'(in_ready), 32'd1);
      chk("rst.wb_out", 32'(wb_out), 32'd0);
      chk("rst.m_out", 32'(m_out), 32'd0);
      chk_cnt("rst", 0, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int k = 0; k < 17; k++) begin
         put(vt[k].iv, vt[k].ordy, 1'b0, vt[k].alu, vt[k].wb, vt[k].m, vt[k].dst);
         step();
         chk($sformatf("v%0d.out_valid", k), 32'(out_valid), 32'(vt[k].e_ov));
         chk($sformatf("v%0d.in_ready", k), 32'(in_ready), 32'(vt[k].e_ir));
         chk($sformatf("v%0d.wb_out", k), 32'(wb_out), 32'(vt[k].e_wb));
         chk($sformatf("v%0d.m_out", k), 32'(m_out), 32'(vt[k].e_m));
         chk_cnt($sformatf("v%0d", k), vt[k].e_s, vt[k].e_b);
         if (vt[k].e_ov) begin
            chk($sformatf("v%0d.alu_out", k), alu_out, vt[k].e_alu);
            chk($sformatf("v%0d.dst_out", k), 32'(dst_out), 32'(vt[k].e_dst));
            chk($sformatf("v%0d.adder_out", k), adder_out, ~vt[k].e_alu);
            chk($sformatf("v%0d.rd2_out", k), rd2_out, vt[k].e_alu ^ RD2_K);
            chk($sformatf("v%0d.zf_out", k), 32'(zf_out), 32'(vt[k].e_alu == 32'd0));
         end
      end

      // flush while in SKID with a simultaneous incoming instruction
      put(1, 0, 0, 32'd20, 2'b11, 3'b111, 5'd20);
      step();
      put(1, 0, 0, 32'd21, 2'b11, 3'b111, 5'd21);
      step();
      chk("fl.skid_in_ready", 32'(in_ready), 32'd0);
      put(1, 0, 1, 32'd22, 2'b11, 3'b111, 5'd22);
      step();
      chk("fl.out_valid", 32'(out_valid), 32'd0);
      chk("fl.in_ready", 32'(in_ready), 32'd1);
      chk("fl.wb_out", 32'(wb_out), 32'd0);
      chk("fl.m_out", 32'(m_out), 32'd0);
      chk_cnt("fl", 4, 4);
      put(0, 0, 0, 32'd0, 2'b00, 3'b000, 5'd0);
      step();
      chk("fl.gone", 32'(out_valid), 32'd0);
      put(1, 1, 0, 32'd23, 2'b11, 3'b111, 5'd23);
      step();
      chk("fl.after_valid", 32'(out_valid), 32'd1);
      chk("fl.after_alu", alu_out, 32'd23);
      chk("fl.after_m", 32'(m_out), 32'd7);
      put(0, 1, 0, 32'd0, 2'b00, 3'b000, 5'd0);
      step();
      chk("fl.drained", 32'(out_valid), 32'd0);
      chk_cnt("fl.end", 4, 6);

      // stall counter saturation, then bubble counter saturation
      es = 4;
      eb = 7;
      put(1, 0, 0, 32'd30, 2'b01, 3'b001, 5'd30);
      step();
      chk_cnt("sat.load", es, eb);
      put(0, 0, 0, 32'd0, 2'b00, 3'b000, 5'd0);
      for (int i = 0; i < 21; i++) begin
         step();
         es = (es == 15) ? 15 : es + 1;
         chk($sformatf("sat.stall%0d", i), 32'(stall_cnt), 32'(es));
      end
      chk("sat.still_valid", 32'(out_valid), 32'd1);
      chk("sat.alu_held", alu_out, 32'd30);
      put(0, 1, 0, 32'd0, 2'b00, 3'b000, 5'd0);
      step();
      chk("sat.drain", 32'(out_valid), 32'd0);
      put(0, 0, 0, 32'd0, 2'b00, 3'b000, 5'd0);
      for (int i = 0; i < 21; i++) begin
         step();
         eb = (eb == 15) ? 15 : eb + 1;
         chk($sformatf("sat.bubble%0d", i), 32'(bubble_cnt), 32'(eb));
      end
      chk_cnt("sat.end", 15, 15);

      // asynchronous reset while in SKID
      put(1, 0, 0, 32'd40, 2'b11, 3'b111, 5'd8);
      step();
      put(1, 0, 0, 32'd41, 2'b11, 3'b111, 5'd9);
      step();
      chk("ar.pre_in_ready", 32'(in_ready), 32'd0);
      chk("ar.pre_m", 32'(m_out), 32'd7);
      #3;
      rst = 1'b1;
      #1;
      chk("ar.out_valid", 32'(out_valid), 32'd0);
      chk("ar.wb_out", 32'(wb_out), 32'd0);
      chk("ar.m_out", 32'(m_out), 32'd0);
      chk("ar.in_ready", 32'(in_ready), 32'd1);
      chk_cnt("ar", 0, 0);
      put(0, 0, 0, 32'd0, 2'b00, 3'b000, 5'd0);
      step();
      rst = 1'b0;
      put(1, 1, 0, 32'd50, 2'b10, 3'b010, 5'd3);
      step();
      chk("ar.after_valid", 32'(out_valid), 32'd1);
      chk("ar.after_alu", alu_out, 32'd50);
      chk_cnt("ar.after", 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
